// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage of the pipelined MIPS core.
// Owns the PC, addresses the instruction memory straight from the PC flop, and
// registers the returned word into the IF/ID pipeline register. One action per
// edge, priority: redirect > stall > advance.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   stall           hazard-unit hold of PC and IF/ID
//   branch_taken    redirect request; branch_target is its byte address
//   imem_addr       byte address to instruction memory (registered PC)
//   imem_rdata      instruction word returned combinationally for imem_addr
//   ifid_instr      registered instruction for decode
//   ifid_pc4        registered PC+4 of that instruction
//   ifid_valid      1 = real instruction, 0 = bubble
//   fetch_count     instructions accepted into IF/ID (saturating)
//   stall_count     cycles spent stalled (saturating)
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] pc_plus4;

  // Modulo-2^32 increment: 32'hFFFF_FFFC wraps to 0 with no flag.
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d          = pc_q;
    instr_d       = instr_q;
    pc4_d         = pc4_q;
    valid_d       = valid_q;
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (branch_taken) begin
      // Flush IF/ID to a nop bubble; stall is ignored and counters are untouched.
      pc_d    = {branch_target[31:2], 2'b00};
      instr_d = 32'h0000_0000;
      pc4_d   = 32'h0000_0000;
      valid_d = 1'b0;
    end else if (stall) begin
      if (stall_count_q != 32'hFFFF_FFFF) begin
        stall_count_d = stall_count_q + 32'd1;
      end
    end else begin
      pc_d    = pc_plus4;
      instr_d = imem_rdata;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      if (fetch_count_q != 32'hFFFF_FFFF) begin
        fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0000_0000;
      pc4_q         <= 32'h0000_0000;
      valid_q       <= 1'b0;
      fetch_count_q <= 32'h0000_0000;
      stall_count_q <= 32'h0000_0000;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pc4_q         <= pc4_d;
      valid_q       <= valid_d;
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign ifid_instr  = instr_q;
  assign ifid_pc4    = pc4_q;
  assign ifid_valid  = valid_q;
  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: the driver applies one action per cycle,
// predicts the post-edge architectural state from a behavioural model and queues
// it; the monitor pops one prediction after every rising edge and compares.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  logic [31:0] imem [64];

  assign imem_rdata = imem[imem_addr[7:2]];

  if_fetch_stage #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .ifid_instr   (ifid_instr),
    .ifid_pc4     (ifid_pc4),
    .ifid_valid   (ifid_valid),
    .fetch_count  (fetch_count),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] fcnt;
    logic [31:0] scnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: architectural state as plain numbers.
  logic [31:0] m_pc, m_instr, m_pc4, m_fcnt, m_scnt;
  logic        m_valid;

  int n_vec;
  int n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".imem_addr"},   imem_addr,   e.addr);
    chk({tag, ".ifid_instr"},  ifid_instr,  e.instr);
    chk({tag, ".ifid_pc4"},    ifid_pc4,    e.pc4);
    chk({tag, ".ifid_valid"},  {31'd0, ifid_valid}, {31'd0, e.valid});
    chk({tag, ".fetch_count"}, fetch_count, e.fcnt);
    chk({tag, ".stall_count"}, stall_count, e.scnt);
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.addr  = m_pc;
    e.instr = m_instr;
    e.pc4   = m_pc4;
    e.valid = m_valid;
    e.fcnt  = m_fcnt;
    e.scnt  = m_scnt;
    return e;
  endfunction

  function automatic void model_reset();
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
    m_fcnt  = 32'h0;
    m_scnt  = 32'h0;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Called at a falling edge: drive one action, predict, then wait for the next
  // falling edge (the monitor checks the prediction in between).
  task automatic step(input logic st, input logic br, input logic [31:0] tgt);
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    if (br) begin
      m_pc    = tgt & 32'hFFFF_FFFC;
      m_instr = 32'h0;
      m_pc4   = 32'h0;
      m_valid = 1'b0;
    end else if (st) begin
      m_scnt = sat_inc(m_scnt);
    end else begin
      m_instr = imem[(m_pc / 4) % 64];
      m_pc    = m_pc + 32'd4;
      m_pc4   = m_pc;
      m_valid = 1'b1;
      m_fcnt  = sat_inc(m_fcnt);
    end
    exp_q.push_back(model_snapshot());
    @(negedge clk);
  endtask

  // Monitor: one prediction per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_all("edge", e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    for (int i = 0; i < 64; i++) imem[i] = $urandom;
    imem[0] = 32'h01095020;
    imem[1] = 32'hAC0A0000;
    rst_n         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    model_reset();
    #1;
    chk_all("reset", model_snapshot());
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Straight-line fetch of IMEM[0], IMEM[1].
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    // Three-cycle stall at pc=8, then resume.
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    // Advance to pc=24, then redirect back to 8.
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h8);
    step(1'b0, 1'b0, 32'h0);
    // Branch and stall together with an unaligned target.
    step(1'b1, 1'b1, 32'h13);
    // Wrap: redirect to the top word and advance once.
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    // Random mix.
    for (int i = 0; i < 400; i++) begin
      logic        st, br;
      logic [31:0] tgt;
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 7) == 0);
      tgt = ($urandom_range(0, 9) == 0) ? $urandom : {24'h0, 8'($urandom)};
      step(st, br, tgt);
    end

    // Saturation: preload both counters just below the ceiling.
    force dut.fetch_count_q = 32'hFFFF_FFFE;
    force dut.stall_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.fetch_count_q;
    release dut.stall_count_q;
    m_fcnt = 32'hFFFF_FFFE;
    m_scnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

    // Async reset while stalled at pc=20.
    step(1'b0, 1'b1, 32'd20);
    step(1'b1, 1'b0, 32'h0);
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all("async_reset", model_snapshot());
    @(negedge clk);
    chk_all("in_reset", model_snapshot());
    rst_n = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the pipelined MIPS core: owns the program counter, drives the word address into the instruction memory, and registers the returned instruction word into the IF/ID pipeline register. It sits directly upstream of the instruction memory's read port and directly upstream of the decode stage. It also applies hazard-unit stalls and branch redirects, and keeps fetch/stall statistics for the bench.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hazard-unit stall (load-use); holds PC and IF/ID.
- branch_taken  input  1  redirect request from decode/branch resolution.
- branch_target  input  32  redirect byte address.
- imem_addr  output  32  byte address to instruction memory (memory indexes word `addr>>2`).
- imem_rdata  input  32  instruction word; combinational response to imem_addr, same cycle.
- ifid_instr  output  32  registered instruction for decode.
- ifid_pc4  output  32  registered PC+4 of that instruction.
- ifid_valid  output  1  1 = ifid_instr is a real fetched instruction; 0 = bubble.
- fetch_count  output  32  number of instructions accepted into IF/ID.
- stall_count  output  32  number of cycles spent stalled.

## Operation
- Internal pc register; imem_addr = pc, driven straight from the flop with no combinational path from any input.
- Each rising edge takes exactly one action. Priority: branch_taken > stall > advance.
- **Redirect** (branch_taken=1, stall ignored):
  - pc <= {branch_target[31:2], 2'b00}.
  - IF/ID flushed: ifid_instr <= 32'h0000_0000 (sll $0,$0,0 = nop), ifid_pc4 <= 0, ifid_valid <= 0.
  - Neither counter changes.
- **Stall** (stall=1, branch_taken=0):
  - pc and all ifid_* outputs hold.
  - stall_count increments.
- **Advance** (both 0):
  - ifid_instr <= imem_rdata, ifid_pc4 <= pc+4, ifid_valid <= 1.
  - pc <= pc+4.
  - fetch_count increments.
- Arithmetic: pc+4 is 32-bit modulo, so 32'hFFFF_FFFC advances to 0 with no flag. The same wrapped value goes to ifid_pc4.
- Counters saturate at 32'hFFFF_FFFF and never wrap.
- There is no other internal state. The block is a PC register, the IF/ID register, and two counters.

## Timing
- Reset (rst_n low, takes effect asynchronously):
  - pc = RESET_PC, so imem_addr = RESET_PC immediately.
  - ifid_instr = 0, ifid_pc4 = 0, ifid_valid = 0.
  - fetch_count = 0, stall_count = 0.
- Reset asserted mid-operation overrides any pending redirect or stall at once. The first edge after release performs a normal action on the then-current inputs.
- Fetch latency: the instruction at address A (imem_addr=A in cycle n) is on ifid_instr after edge n, with ifid_pc4 = A+4.
- Branch penalty: exactly one bubble. With branch_taken sampled at edge n:
  - after edge n: ifid_valid = 0 and imem_addr = target.
  - after edge n+1: ifid_instr = IMEM[target>>2], ifid_valid = 1 (assuming no stall).
- Stall: a stall of k consecutive cycles holds ifid_* and imem_addr constant for k cycles. stall_count grows by k.
- branch_taken and stall together in the same cycle is treated as a redirect. This flush takes precedence over the hazard hold.

## Test plan
- Reset/straight-line: memory preloaded with IMEM[0]=32'h01095020 and IMEM[1]=32'hAC0A0000; release rst_n.
  - After edge 1: ifid_instr=32'h01095020, ifid_pc4=4, ifid_valid=1.
  - After edge 2: ifid_instr=32'hAC0A0000, ifid_pc4=8, fetch_count=2, imem_addr=8.
- Stall: stall=1 for 3 cycles at pc=8.
  - ifid_instr and imem_addr=8 hold for 3 cycles; stall_count=3; fetch_count unchanged.
  - On release, the next edge loads IMEM[2], ifid_pc4=12.
- Redirect: branch_taken=1, branch_target=32'h8 at pc=24 (beq $11,$8,-4 case).
  - Next edge: ifid_valid=0, ifid_instr=0, imem_addr=8.
  - Following edge: ifid_instr=IMEM[2], ifid_pc4=12.
- Branch and stall together: branch_taken=1, stall=1, target=32'h13.
  - Next edge: pc=32'h10 (low bits cleared), ifid_valid=0, stall_count unchanged.
- Wrap and saturation:
  - Redirect to 32'hFFFF_FFFC, then advance once: ifid_pc4=0, imem_addr=0.
  - Force fetch_count near 32'hFFFF_FFFF via a long run or a bench-forced value: it stays at 32'hFFFF_FFFF.
- Async reset mid-run: drop rst_n between edges while stalled at pc=20.
  - Immediately: imem_addr=RESET_PC, ifid_valid=0, both counters 0, with no clock edge required.
